// File: rtl/mdu.sv
//------------------------------------------------------------------------------
// Module   : mdu
// Brief    : Multi-cycle multiply/divide unit owning the HI/LO registers.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam logic [3:0] c_mult_n = MULT_CYCLES[3:0];
    localparam logic [3:0] c_div_n  = DIV_CYCLES[3:0];

    logic [3:0]  r_count;
    logic [31:0] r_phi;
    logic [31:0] r_plo;
    logic        r_pwrite;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_dvs_safe;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign busy = (r_count != 4'd0);

    // Sign-extending to 64 bits makes the truncated 64x64 product the signed result.
    assign w_prod_s = {{32{operand1[31]}}, operand1} * {{32{operand2[31]}}, operand2};
    assign w_prod_u = {32'd0, operand1} * {32'd0, operand2};

    // Signed division runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign w_neg_a    = (op == c_op_div) & operand1[31];
    assign w_neg_b    = (op == c_op_div) & operand2[31];
    assign w_dvd      = w_neg_a ? -operand1 : operand1;
    assign w_dvs      = w_neg_b ? -operand2 : operand2;
    assign w_dvs_safe = (w_dvs == 32'd0) ? 32'd1 : w_dvs;
    assign w_quo      = w_dvd / w_dvs_safe;
    assign w_rem      = w_dvd % w_dvs_safe;
    assign w_q        = (w_neg_a ^ w_neg_b) ? -w_quo : w_quo;
    assign w_r        = w_neg_a ? -w_rem : w_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= 4'd0;
            r_phi    <= 32'd0;
            r_plo    <= 32'd0;
            r_pwrite <= 1'b0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else if (busy) begin
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1 && r_pwrite) begin
                hi <= r_phi;
                lo <= r_plo;
            end
        end else if (start) begin
            case (op)
                c_op_mult: begin
                    {r_phi, r_plo} <= w_prod_s;
                    r_pwrite       <= 1'b1;
                    r_count        <= c_mult_n;
                end
                c_op_multu: begin
                    {r_phi, r_plo} <= w_prod_u;
                    r_pwrite       <= 1'b1;
                    r_count        <= c_mult_n;
                end
                c_op_div, c_op_divu: begin
                    r_phi    <= w_r;
                    r_plo    <= w_q;
                    // A zero divisor still occupies the unit but never commits.
                    r_pwrite <= (operand2 != 32'd0);
                    r_count  <= c_div_n;
                end
                c_op_mthi: hi <= operand1;
                c_op_mtlo: lo <= operand1;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu.sv
//------------------------------------------------------------------------------
// Module   : tb_mdu
// Brief    : Self-checking bench for mdu against an arithmetic reference model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mdu;

    localparam logic [2:0] c_none  = 3'd0;
    localparam logic [2:0] c_mult  = 3'd1;
    localparam logic [2:0] c_multu = 3'd2;
    localparam logic [2:0] c_div   = 3'd3;
    localparam logic [2:0] c_divu  = 3'd4;
    localparam logic [2:0] c_mthi  = 3'd5;
    localparam logic [2:0] c_mtlo  = 3'd6;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int ncyc(input logic [2:0] o);
        if (o == c_mult || o == c_multu) return 5;
        if (o == c_div || o == c_divu) return 10;
        return 0;
    endfunction

    // Architectural effect of one accepted operation on HI/LO.
    function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            c_mult:  begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
            c_multu: begin p = {32'd0, a} * {32'd0, b}; h = p[63:32]; l = p[31:0]; end
            c_div:   if (b != 0) begin p = 64'(sa / sb); l = p[31:0]; p = 64'(sa % sb); h = p[31:0]; end
            c_divu:  if (b != 0) begin l = a / b; h = a % b; end
            c_mthi:  h = a;
            c_mtlo:  l = a;
            default: ;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = ncyc(o);
        ref_op(o, a, b, exp_hi, exp_lo);
        @(negedge clk);
        start = 1'b1; op = o; operand1 = a; operand2 = b;
        @(negedge clk);
        start = 1'b0; op = c_none; operand1 = $urandom; operand2 = $urandom;
        for (int i = 0; i < n; i++) begin
            chk("busy_during", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("hi", hi, exp_hi);
        chk("lo", lo, exp_lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1; start = 1'b0; op = c_none; operand1 = '0; operand2 = '0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(c_mult, 32'hFFFFFFFE, 32'h00000003);
        chk("mult_hi_const", hi, 32'hFFFFFFFF);
        chk("mult_lo_const", lo, 32'hFFFFFFFA);
        run_op(c_multu, 32'hFFFFFFFE, 32'h00000003);
        chk("multu_hi_const", hi, 32'h00000002);
        chk("multu_lo_const", lo, 32'hFFFFFFFA);
        run_op(c_div, 32'hFFFFFFF9, 32'h00000002);
        chk("div_lo_const", lo, 32'hFFFFFFFD);
        chk("div_hi_const", hi, 32'hFFFFFFFF);
        run_op(c_divu, 32'd7, 32'd2);
        chk("divu_lo_const", lo, 32'd3);
        chk("divu_hi_const", hi, 32'd1);
        run_op(c_div, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf_lo_const", lo, 32'h80000000);
        chk("divovf_hi_const", hi, 32'h00000000);

        run_op(c_mtlo, 32'h12345678, 32'd0);
        chk("mtlo_const", lo, 32'h12345678);
        run_op(c_mthi, 32'h11111111, 32'd0);
        run_op(c_mtlo, 32'h22222222, 32'd0);
        run_op(c_divu, 32'h00000055, 32'd0);
        chk("div0_hi_const", hi, 32'h11111111);
        chk("div0_lo_const", lo, 32'h22222222);
        run_op(c_none, 32'hAAAA5555, 32'd1);
        run_op(3'd7, 32'hAAAA5555, 32'd1);

        // MTHI held on start through the busy period and past its final edge.
        ref_op(c_mult, 32'h00012345, 32'hFFFF0000, exp_hi, exp_lo);
        @(negedge clk);
        start = 1'b1; op = c_mult; operand1 = 32'h00012345; operand2 = 32'hFFFF0000;
        @(negedge clk);
        start = 1'b0; op = c_none;
        chk("mt_busy_c1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b1; op = c_mthi; operand1 = 32'hDEADBEEF; operand2 = 32'h0BADF00D;
        for (int i = 2; i <= 5; i++) begin
            chk("mt_busy_cn", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        chk("mt_busy_end", {31'd0, busy}, 32'd0);
        chk("mt_hi_product", hi, exp_hi);
        chk("mt_lo_product", lo, exp_lo);
        @(negedge clk);
        start = 1'b0; op = c_none;
        exp_hi = 32'hDEADBEEF;
        chk("mt_hi_after", hi, exp_hi);
        chk("mt_lo_after", lo, exp_lo);

        // Reset in the middle of busy cycle 4 of a divide.
        @(negedge clk);
        start = 1'b1; op = c_div; operand1 = 32'd100; operand2 = 32'd7;
        @(negedge clk);
        start = 1'b0; op = c_none;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b1; op = c_mtlo; operand1 = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0; op = c_none;
        exp_lo = 32'hCAFEF00D;
        chk("post_rst_mtlo", lo, exp_lo);
        repeat (12) @(negedge clk);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_hi", hi, exp_hi);
        chk("post_rst_lo", lo, exp_lo);

        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
